// File: rtl/pcpi_mm_pkg.sv
// Shared constants and FSM state type for the PCPI matrix-coprocessor issuer.
// Latency: none (declarations only).
// Backpressure: n/a.
package pcpi_mm_pkg;

  // Major opcode for every insn sent to the coprocessor.
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  // funct3 selects the coprocessor operation.
  localparam logic [2:0] F3_LOAD  = 3'b000;
  localparam logic [2:0] F3_CLEAR = 3'b101;
  localparam logic [2:0] F3_START = 3'b111;

  // Shadow bank layout: matrix A, matrix B, bias vector, then a single threshold.
  localparam logic [4:0] A_BASE      = 5'd0;
  localparam logic [4:0] B_BASE      = 5'd9;
  localparam logic [4:0] BIAS_BASE   = 5'd18;
  localparam logic [4:0] THRESH_ADDR = 5'd27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOAD,
    ST_START,
    ST_SETTLE,
    ST_WAIT,
    ST_CLEAR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pcpi_mm_insn_enc.sv
// Packs {funct3, addr, value} into a custom-0 PCPI instruction word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3_i/addr_i/value_i fields in, insn_o = {0, value, funct3, addr, OPC_CUSTOM0}.
module pcpi_mm_insn_enc
  import pcpi_mm_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  addr_i,
  input  logic [15:0] value_i,
  output logic [31:0] insn_o
);

  assign insn_o = {1'b0, value_i, funct3_i, addr_i, OPC_CUSTOM0};

endmodule

// File: rtl/pcpi_matrix_issuer.sv
// PCPI initiator: streams one LOAD per dirty shadow entry, then START, captures the result, then CLEAR.
// Latency: 28 scan cycles + 1 per accepted LOAD + 3 (START/SETTLE/DONE) + responder stalls.
// Backpressure: LOAD and CLEAR hold pcpi_valid/pcpi_insn stable until pcpi_ready; START is a 1-cycle pulse.
// Ports: cfg_we/cfg_addr/cfg_wdata write the shadow bank in IDLE; go starts a sequence; busy/done/
//   result/result_valid/err_timeout report status; pcpi_* is the coprocessor initiator interface.
// Optional: define PCPI_ISSUER_TIMEOUT_EN to bound the result wait to TIMEOUT_CYCLES (sets err_timeout).
module pcpi_matrix_issuer
  import pcpi_mm_pkg::*;
#(
  parameter int NUM_REGS       = 28,
  parameter int VALUE_W        = 16,   // must stay 16: occupies insn[30:15]
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        err_timeout,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic [31:0]         result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic [VALUE_W-1:0]  bank_q [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q;

  logic                cfg_wr_en;
  logic                load_ack;
  logic                enc_vld;
  logic [2:0]          enc_f3;
  logic [4:0]          enc_addr;
  logic [VALUE_W-1:0]  enc_val;
  logic [31:0]         enc_insn;

`ifdef PCPI_ISSUER_TIMEOUT_EN
  localparam int          TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Writes land only while idle; out-of-range indices are dropped rather than aliased.
  assign cfg_wr_en = cfg_we && (state_q == ST_IDLE) && ({27'd0, cfg_addr} < 32'(NUM_REGS));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    load_ack       = 1'b0;
    enc_vld        = 1'b0;
    enc_f3         = F3_LOAD;
    enc_addr       = 5'd0;
    enc_val        = '0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
    tmo_d          = tmo_q;
    err_d          = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d        = ST_SCAN;
          idx_d          = 5'd0;
          result_valid_d = 1'b0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
          err_d          = 1'b0;
`endif
        end
      end

      ST_SCAN: begin
        if (dirty_q[idx_q]) begin
          state_d = ST_LOAD;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_START;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end

      ST_LOAD: begin
        enc_vld  = 1'b1;
        enc_addr = idx_q;
        enc_val  = bank_q[idx_q];
        if (pcpi_ready) begin
          load_ack = 1'b1;
          state_d  = ST_SCAN;
          // The last entry is revisited once in SCAN (now clean), which keeps a
          // valid-low gap before START and terminates the scan there.
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      ST_START: begin
        enc_vld = 1'b1;
        enc_f3  = F3_START;
        state_d = ST_SETTLE;
      end

      // pcpi_ready here still reflects the coprocessor's view before START; ignore it.
      ST_SETTLE: begin
        state_d = ST_WAIT;
`ifdef PCPI_ISSUER_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      ST_WAIT: begin
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            result_d       = pcpi_rd;
            result_valid_d = 1'b1;
          end
          state_d = ST_CLEAR;
        end
`ifdef PCPI_ISSUER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      ST_CLEAR: begin
        enc_vld = 1'b1;
        enc_f3  = F3_CLEAR;
        if (pcpi_ready) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      idx_q          <= 5'd0;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
`ifdef PCPI_ISSUER_TIMEOUT_EN
      tmo_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
`ifdef PCPI_ISSUER_TIMEOUT_EN
      tmo_q          <= tmo_d;
      err_q          <= err_d;
`endif
    end
  end

  // Shadow bank and dirty bits. cfg writes (IDLE) and load acks (LOAD) never coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dirty_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      if (load_ack) begin
        dirty_q[idx_q] <= 1'b0;
      end
      if (cfg_wr_en) begin
        bank_q[cfg_addr]  <= cfg_wdata;
        dirty_q[cfg_addr] <= 1'b1;
      end
    end
  end

  pcpi_mm_insn_enc u_enc (
    .funct3_i (enc_f3),
    .addr_i   (enc_addr),
    .value_i  (enc_val),
    .insn_o   (enc_insn)
  );

  // Outputs decode straight from state so pcpi_valid falls with the async reset.
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign pcpi_valid   = enc_vld;
  assign pcpi_insn    = enc_vld ? enc_insn : 32'd0;
  assign result       = result_q;
  assign result_valid = result_valid_q;

`ifdef PCPI_ISSUER_TIMEOUT_EN
  assign err_timeout = err_q;
  logic unused_ok;
  assign unused_ok = pcpi_wait;
`else
  assign err_timeout = 1'b0;
  // pcpi_wait is informational only; the wait is unbounded in this build.
  logic unused_ok;
  assign unused_ok = ^{pcpi_wait, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_pcpi_matrix_issuer.sv
module tb_pcpi_matrix_issuer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        go;
  logic        busy, done, result_valid, err_timeout, pcpi_valid;
  logic [31:0] result, pcpi_insn;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  int checks   = 0;
  int failures = 0;

  // Scoreboard and responder configuration
  logic [31:0] exp_q[$];
  int          stall_cfg  = 0;
  int          wait_delay = 0;
  logic        resp_wr    = 1'b0;
  logic [31:0] resp_rd    = 32'd0;

  localparam logic [31:0] BAIT    = 32'hDEAD_BEEF;
  localparam logic [31:0] I_START = 32'h0000_700B;
  localparam logic [31:0] I_CLEAR = 32'h0000_500B;

  pcpi_matrix_issuer dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .go           (go),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .err_timeout  (err_timeout),
    .pcpi_valid   (pcpi_valid),
    .pcpi_insn    (pcpi_insn),
    .pcpi_wr      (pcpi_wr),
    .pcpi_rd      (pcpi_rd),
    .pcpi_wait    (pcpi_wait),
    .pcpi_ready   (pcpi_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Responder + monitor: decides pcpi_ready for the coming edge and pops the
  // scoreboard whenever an insn is accepted.
  int          hold_cnt = 0;
  logic        holding  = 1'b0;
  logic [31:0] held     = 32'd0;
  int          phase    = 0;   // 0 normal, 1 expect SETTLE, 2 in WAIT
  int          wcnt     = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      hold_cnt = 0; holding = 1'b0; phase = 0; wcnt = 0;
      pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
    end else begin
      pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
      if (holding) begin
        chk("hold_valid", {31'd0, pcpi_valid}, 32'd1);
        chk("hold_insn", pcpi_insn, held);
      end
      holding = 1'b0;
      if (phase == 1) begin
        chk("start_one_cycle", {31'd0, pcpi_valid}, 32'd0);
        // Bait during SETTLE: must not be captured.
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = BAIT;
        phase = 2; wcnt = 0;
      end else if (pcpi_valid) begin
        phase = 0;
        if (pcpi_insn[14:12] == 3'b111) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_insn: got 0x%08h expected none", pcpi_insn);
          end else chk("insn", pcpi_insn, exp_q.pop_front());
          phase = 1;
        end else if (hold_cnt < stall_cfg) begin
          if (hold_cnt == 0) held = pcpi_insn;
          hold_cnt++;
          holding = 1'b1;
        end else begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_insn: got 0x%08h expected none", pcpi_insn);
          end else chk("insn", pcpi_insn, exp_q.pop_front());
          pcpi_ready = 1'b1;
          hold_cnt = 0;
        end
      end else if (phase == 2) begin
        if (wcnt < wait_delay) wcnt++;
        else begin
          pcpi_ready = 1'b1; pcpi_wr = resp_wr; pcpi_rd = resp_rd;
          phase = 0;
        end
      end
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Issue go (optionally with a same-edge write), optionally attempt a write
  // while busy, then wait for done and check the pulse count and drain.
  task automatic run_go(input logic same_we, input logic [4:0] a, input logic [15:0] d,
                        input logic mid_we);
    int ndone;
    logic seen;
    @(negedge clk);
    go = 1'b1; cfg_we = same_we; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    go = 1'b0; cfg_we = 1'b0;
    chk("busy_after_go", {31'd0, busy}, 32'd1);
    chk("rv_cleared_on_go", {31'd0, result_valid}, 32'd0);
    if (mid_we) begin
      cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = 16'h7777;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    ndone = seen ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("done_pulses", ndone, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_v;
    resetn = 1'b0; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_wdata = 16'd0; go = 1'b0;
    pcpi_wait = 1'b0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("rst_insn", pcpi_insn, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // 1: single load of A[0]=3, no result write
    wait_delay = 1; resp_wr = 1'b0; resp_rd = 32'h0000_0055;
    cfg_write(5'd0, 16'd3);
    exp_q.push_back(32'h0001_800B); exp_q.push_back(I_START); exp_q.push_back(I_CLEAR);
    run_go(1'b0, 5'd0, 16'd0, 1'b0);
    chk("s1_result", result, 32'd0);
    chk("s1_rv", {31'd0, result_valid}, 32'd0);

    // 2+4: threshold = -70, result written; write during busy must be dropped
    wait_delay = 0; resp_wr = 1'b1; resp_rd = 32'h0000_01FF;
    cfg_write(5'd27, 16'hFFBA);
    exp_q.push_back(32'h7FDD_0D8B); exp_q.push_back(I_START); exp_q.push_back(I_CLEAR);
    run_go(1'b0, 5'd0, 16'd0, 1'b1);
    chk("s2_result", result, 32'h0000_01FF);
    chk("s2_rv", {31'd0, result_valid}, 32'd1);
    repeat (5) @(negedge clk);
    chk("s2_rv_sticky", {31'd0, result_valid}, 32'd1);

    // 3: no dirty entries (out-of-range write ignored) -> START/CLEAR only
    wait_delay = 2; resp_wr = 1'b0; resp_rd = 32'h1234_5678;
    cfg_write(5'd30, 16'h0005);
    exp_q.push_back(I_START); exp_q.push_back(I_CLEAR);
    run_go(1'b0, 5'd0, 16'd0, 1'b0);
    chk("s3_result_kept", result, 32'h0000_01FF);
    chk("s3_rv", {31'd0, result_valid}, 32'd0);

    // 4: responder stalls 2 cycles per insn; same-edge write with go is included
    stall_cfg = 2; wait_delay = 3; resp_wr = 1'b1; resp_rd = 32'hCAFE_0001;
    cfg_write(5'd5, 16'h0123);
    cfg_write(5'd18, 16'h8000);
    exp_q.push_back(32'h0091_828B); exp_q.push_back(32'h0055_048B);
    exp_q.push_back(32'h4000_090B); exp_q.push_back(I_START); exp_q.push_back(I_CLEAR);
    run_go(1'b1, 5'd9, 16'h00AA, 1'b0);
    chk("s4_result", result, 32'hCAFE_0001);
    chk("s4_rv", {31'd0, result_valid}, 32'd1);

    // 5: reset in the middle of a stalled LOAD
    stall_cfg = 20; wait_delay = 0; resp_wr = 1'b1; resp_rd = 32'h0000_0042;
    cfg_write(5'd3, 16'h0011);
    cfg_write(5'd4, 16'h0022);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    seen_v = 1'b0;
    for (int c = 0; c < 60 && !seen_v; c++) begin
      @(negedge clk);
      if (pcpi_valid) seen_v = 1'b1;
    end
    chk("s5_first_load", pcpi_insn, 32'h0008_818B);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("s5_async_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("s5_async_busy", {31'd0, busy}, 32'd0);
    chk("s5_async_insn", pcpi_insn, 32'd0);
    chk("s5_async_rv", {31'd0, result_valid}, 32'd0);
    chk("s5_async_result", result, 32'd0);
    @(negedge clk);
    exp_q.delete();
    stall_cfg = 0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.push_back(I_START); exp_q.push_back(I_CLEAR);
    run_go(1'b0, 5'd0, 16'd0, 1'b0);
    chk("s5_result", result, 32'h0000_0042);
    chk("s5_rv", {31'd0, result_valid}, 32'd1);
    chk("final_err", {31'd0, err_timeout}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
